tc0480scp_rom_responder: RTL and testbench
==========================================

# tc0480scp_rom_responder

Responder end of the tilemap graphics-ROM toggle handshake. It accepts one outstanding 64-bit fetch at a time from the TC0480SCP background path (`rom_req`/`rom_ack`/`rom_address`/`rom_data`), services it with a 4-beat 16-bit burst on the shared memory port, then returns the assembled word. A single-entry last-fetch cache answers repeated fetches of the same 8-byte row without a memory access. It sits between the tilemap chip and the SDRAM arbiter in the video subsystem.

## Interface
- `ROM_BASE`, 27'h0, byte offset added to every fetch address on the memory port
- `CACHE_EN`, 1, 1 enables the single-entry cache; 0 forces every fetch to miss
- `clk`  in  1  system clock; the only clock
- `reset_n`  in  1  asynchronous, active-low reset
- `rom_address`  in  23  byte address from the requester; bits [2:0] ignored
- `rom_req`  in  1  request toggle; a request is pending while `rom_req != rom_ack`
- `rom_ack`  out  1  acknowledge toggle; reset 0
- `rom_data`  out  64  fetched row; beat k on bits [16k+15:16k]; reset 0
- `flush`  in  1  invalidate cache, e.g. during ROM download
- `mem_req`  out  1  burst request level; reset 0
- `mem_addr`  out  27  burst byte address, 8-byte aligned; reset 0
- `mem_gnt`  in  1  one-cycle grant; burst accepted
- `mem_rdata`  in  16  read beat
- `mem_rvalid`  in  1  beat valid; exactly 4 per granted burst

## Operation
- States: IDLE, LOOKUP, REQ, BURST, DONE.
- IDLE: on `rom_req != rom_ack`, latch `rom_address[22:3]` into `addr_q` and go to LOOKUP.
- LOOKUP: hit when `CACHE_EN && tag_valid && tag == addr_q && !flush`. On hit, set `rom_data` from the cache line and go to DONE. On miss, set `mem_addr = ROM_BASE + {addr_q, 3'b0}` (27-bit wrap), assert `mem_req`, and go to REQ.
- REQ: hold `mem_req` and `mem_addr` until `mem_gnt`. On grant, drop `mem_req`, clear `beat` (2 bits), and go to BURST.
- BURST: each `mem_rvalid` writes `mem_rdata` into slice `beat` of `line_q` and increments `beat`. On the 4th beat (`beat == 3`), go to DONE.
- DONE: on a miss path, `rom_data <= line_q`, `tag <= addr_q`, and `tag_valid <= CACHE_EN && !flush_seen`. In all cases toggle `rom_ack` (`rom_ack <= rom_req` as sampled at acceptance), then return to IDLE.
- `flush`:
  - clears `tag_valid` in any state.
  - Asserted at any point between acceptance and DONE on a miss path, it sets `flush_seen`, which prevents that line being cached. `flush_seen` clears in IDLE.
- `mem_rvalid` outside BURST is discarded.
- `rom_data` changes only in DONE and stays stable between acks.
- Requester protocol: `rom_req` does not toggle again before `rom_ack` matches. A re-toggle during service is not tracked. Only the level comparison in IDLE starts a fetch.

## Timing
- Request visible at edge N (IDLE), LOOKUP at N+1, DONE at N+2 on a hit. `rom_ack` and `rom_data` update at edge N+3. Hit latency is 3 cycles.
- Miss: `mem_req` high from edge N+2 until the cycle after `mem_gnt`. DONE is entered at the edge that captures the 4th beat, and `rom_ack` toggles one edge later.
- Back-to-back: a new request seen in the IDLE cycle directly after DONE is accepted. No idle gap beyond that cycle.
- Async reset mid-burst forces IDLE and clears `mem_req`, `rom_ack`, `rom_data`, `tag_valid`, and `beat`. The memory port is reset in the same domain, so no stale beats arrive.

## Structure
- Shared package `tc0480scp_pkg`: `rom_resp_state_t` enum (the 5 states) and `ROM_BEATS = 4`.
- One natural sub-module, `tc0480scp_line_cache`. It holds tag, valid and the 64-bit line, with inputs for lookup, fill and flush.

## Test plan
- Miss fetch:
  - Stimulus: `rom_address = 23'h012348`, toggle `rom_req`; grant after 2 cycles; beats `1111`, `2222`, `3333`, `4444`.
  - Response: `mem_addr = ROM_BASE + 27'h012348`, `rom_data = 64'h4444_3333_2222_1111`, `rom_ack` toggles exactly once, 1 cycle after the last beat.
- Hit:
  - Stimulus: same address again.
  - Response: no `mem_req`, `rom_ack` toggles 3 cycles after the `rom_req` toggle, `rom_data` unchanged.
- Flush:
  - Stimulus: pulse `flush`, then re-request the same address.
  - Response: full burst issued. A `flush` during a burst prevents that line from hitting next time.
- Low address bits:
  - Stimulus: `rom_address[2:0] = 3'b101`.
  - Response: `mem_addr[2:0] = 0`, and a hit on the aligned tag.
- `CACHE_EN = 0`:
  - Stimulus: repeated identical requests.
  - Response: every request issues a burst.
- Reset mid-burst:
  - Stimulus: `reset_n` low after the 2nd beat, then released.
  - Response: `rom_ack = 0`, `mem_req = 0`. The next request performs a full 4-beat burst and a miss.

Source files
------------

// File: rtl/tc0480scp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tc0480scp_pkg
//  Description : Shared types and constants for the TC0480SCP graphics-ROM
//                responder (FSM state encoding, burst geometry).
//  Revision    : 1.0 - initial release
// ============================================================================
package tc0480scp_pkg;

    // Number of 16-bit beats that make up one 64-bit tile row
    localparam int ROM_BEATS = 4;

    // Width of an 8-byte row index taken from the 23-bit byte address
    localparam int ROW_W = 20;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        REQ    = 3'd2,
        BURST  = 3'd3,
        DONE   = 3'd4
    } rom_resp_state_t;

endpackage
`default_nettype wire

// File: rtl/tc0480scp_line_cache.sv
`default_nettype none
// ============================================================================
//  Module      : tc0480scp_line_cache
//  Description : Single-entry last-fetch cache. Holds one row tag, its valid
//                flag and the 64-bit row data. Flush always wins over fill.
//  Revision    : 1.0 - initial release
// ============================================================================
module tc0480scp_line_cache
    import tc0480scp_pkg::*;
#(
    parameter bit CACHE_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [ROW_W-1:0] i_lookup_tag,
    input  logic             i_flush,
    input  logic             i_fill,
    input  logic [ROW_W-1:0] i_fill_tag,
    input  logic [63:0]      i_fill_line,
    input  logic             i_fill_valid,
    output logic             o_hit,
    output logic [63:0]      o_line
);

    logic [ROW_W-1:0] r_tag;
    logic             r_valid;
    logic [63:0]      r_line;

    // Tag/line storage; a flush in the same cycle as a fill leaves the entry invalid
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tag   <= '0;
            r_valid <= 1'b0;
            r_line  <= '0;
        end else begin
            if (i_fill) begin
                r_tag  <= i_fill_tag;
                r_line <= i_fill_line;
            end
            if (i_flush) begin
                r_valid <= 1'b0;
            end else if (i_fill) begin
                r_valid <= CACHE_EN && i_fill_valid;
            end
        end
    end

    // A flush presented during lookup must not return the entry it is killing
    assign o_hit  = CACHE_EN && r_valid && (r_tag == i_lookup_tag) && !i_flush;
    assign o_line = r_line;

endmodule
`default_nettype wire

// File: rtl/tc0480scp_rom_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tc0480scp_rom_responder
//  Description : Responder side of the TC0480SCP tile-ROM toggle handshake.
//                Serves one 64-bit row fetch at a time, from the last-fetch
//                cache or via a 4-beat 16-bit burst on the memory port.
//  Revision    : 1.0 - initial release
// ============================================================================
module tc0480scp_rom_responder
    import tc0480scp_pkg::*;
#(
    parameter logic [26:0] ROM_BASE = 27'h0,
    parameter bit          CACHE_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [22:0] rom_address,
    input  logic        rom_req,
    output logic        rom_ack,
    output logic [63:0] rom_data,
    input  logic        flush,
    output logic        mem_req,
    output logic [26:0] mem_addr,
    input  logic        mem_gnt,
    input  logic [15:0] mem_rdata,
    input  logic        mem_rvalid
);

    rom_resp_state_t  r_state;
    rom_resp_state_t  w_state_next;

    logic [ROW_W-1:0] r_addr_q;
    logic             r_req_q;
    logic             r_miss;
    logic             r_flush_seen;
    logic [1:0]       r_beat;
    logic [63:0]      r_line_q;

    logic             w_accept;
    logic             w_hit_take;
    logic             w_miss_take;
    logic             w_grant;
    logic             w_beat;
    logic             w_finish;
    logic             w_hit;
    logic [63:0]      w_cache_line;

    // Row granularity is 8 bytes; the byte offset inside a row is irrelevant
    logic             w_unused_lsbs;
    assign w_unused_lsbs = ^rom_address[2:0];

    tc0480scp_line_cache #(
        .CACHE_EN (CACHE_EN)
    ) u_line_cache (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_lookup_tag (r_addr_q),
        .i_flush      (flush),
        .i_fill       (w_finish && r_miss),
        .i_fill_tag   (r_addr_q),
        .i_fill_line  (r_line_q),
        .i_fill_valid (!r_flush_seen),
        .o_hit        (w_hit),
        .o_line       (w_cache_line)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and one-cycle datapath strobes
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_hit_take   = 1'b0;
        w_miss_take  = 1'b0;
        w_grant      = 1'b0;
        w_beat       = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            IDLE: begin
                if (rom_req != rom_ack) begin
                    w_accept     = 1'b1;
                    w_state_next = LOOKUP;
                end
            end
            LOOKUP: begin
                if (w_hit) begin
                    w_hit_take   = 1'b1;
                    w_state_next = DONE;
                end else begin
                    w_miss_take  = 1'b1;
                    w_state_next = REQ;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    w_grant      = 1'b1;
                    w_state_next = BURST;
                end
            end
            BURST: begin
                if (mem_rvalid) begin
                    w_beat = 1'b1;
                    if (r_beat == 2'(ROM_BEATS - 1)) begin
                        w_state_next = DONE;
                    end
                end
            end
            DONE: begin
                w_finish     = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Request capture, memory port, beat assembly and response registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr_q     <= '0;
            r_req_q      <= 1'b0;
            r_miss       <= 1'b0;
            r_flush_seen <= 1'b0;
            r_beat       <= 2'd0;
            r_line_q     <= '0;
            mem_req      <= 1'b0;
            mem_addr     <= '0;
            rom_ack      <= 1'b0;
            rom_data     <= '0;
        end else begin
            if (w_accept) begin
                r_addr_q <= rom_address[22:3];
                r_req_q  <= rom_req;
                r_miss   <= 1'b0;
            end

            // Any flush after acceptance keeps the in-flight row out of the cache
            if (r_state == IDLE) begin
                r_flush_seen <= w_accept && flush;
            end else if (flush) begin
                r_flush_seen <= 1'b1;
            end

            if (w_hit_take) begin
                r_line_q <= w_cache_line;
            end

            if (w_miss_take) begin
                mem_req  <= 1'b1;
                mem_addr <= ROM_BASE + {4'b0000, r_addr_q, 3'b000};
                r_miss   <= 1'b1;
            end

            if (w_grant) begin
                mem_req <= 1'b0;
                r_beat  <= 2'd0;
            end

            if (w_beat) begin
                r_line_q[{r_beat, 4'b0000} +: 16] <= mem_rdata;
                r_beat                            <= r_beat + 2'd1;
            end

            if (w_finish) begin
                rom_data <= r_line_q;
                rom_ack  <= r_req_q;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tc0480scp_rom_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tc0480scp_rom_responder
//  Description : Self-checking bench. Two responders (cache on / cache off)
//                share a reactive memory model; a row-level reference model
//                predicts data, hit/miss, burst address and latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tc0480scp_rom_responder;

    localparam logic [26:0] BASE = 27'h7F0_0000;

    logic              clk;
    logic              reset_n;
    logic [1:0][22:0]  rom_address;
    logic [1:0]        rom_req;
    logic [1:0]        flush;
    logic [1:0]        mem_gnt;
    logic [1:0]        mem_rvalid;
    logic [1:0][15:0]  mem_rdata;

    logic              a_ack, b_ack, a_mreq, b_mreq;
    logic [63:0]       a_data, b_data;
    logic [26:0]       a_maddr, b_maddr;
    logic [1:0]        ack_v, mreq_v;
    logic [1:0][63:0]  data_v;
    logic [1:0][26:0]  maddr_v;

    assign ack_v   = {b_ack, a_ack};
    assign mreq_v  = {b_mreq, a_mreq};
    assign data_v  = {b_data, a_data};
    assign maddr_v = {b_maddr, a_maddr};

    tc0480scp_rom_responder #(.ROM_BASE(BASE), .CACHE_EN(1'b1)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .rom_address(rom_address[0]), .rom_req(rom_req[0]),
        .rom_ack(a_ack), .rom_data(a_data), .flush(flush[0]), .mem_req(a_mreq),
        .mem_addr(a_maddr), .mem_gnt(mem_gnt[0]), .mem_rdata(mem_rdata[0]),
        .mem_rvalid(mem_rvalid[0])
    );

    tc0480scp_rom_responder #(.ROM_BASE(BASE), .CACHE_EN(1'b0)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .rom_address(rom_address[1]), .rom_req(rom_req[1]),
        .rom_ack(b_ack), .rom_data(b_data), .flush(flush[1]), .mem_req(b_mreq),
        .mem_addr(b_maddr), .mem_gnt(mem_gnt[1]), .mem_rdata(mem_rdata[1]),
        .mem_rvalid(mem_rvalid[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ROM image: explicit entries override a fixed address hash
    logic [63:0] img [logic [26:0]];

    function automatic logic [63:0] img_read(input logic [26:0] a);
        if (img.exists(a)) return img[a];
        return {5'b0, a, 5'b0, a} ^ 64'h0123_4567_89AB_CDEF;
    endfunction

    // Memory model state
    int          phase[2];
    int          cnt[2];
    int          beat_cnt[2];
    int          bursts[2];
    int          last_beat_cyc[2];
    int          gnt_delay[2];
    logic [26:0] burst_addr[2];
    logic [63:0] word[2];
    bit          junk_en;

    // Reactive memory: grant after a delay, then exactly 4 beats with random gaps
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            mem_gnt[k]    = 1'b0;
            mem_rvalid[k] = 1'b0;
            mem_rdata[k]  = 16'($urandom);
            if (!reset_n) begin
                phase[k] = 0;
            end else if (phase[k] == 0) begin
                if (mreq_v[k]) begin
                    cnt[k]   = (gnt_delay[k] < 0) ? int'($urandom_range(0, 3)) : gnt_delay[k];
                    phase[k] = 1;
                end else if (junk_en && $urandom_range(0, 3) == 0) begin
                    mem_rvalid[k] = 1'b1;
                end
            end else if (phase[k] == 1) begin
                if (cnt[k] == 0) begin
                    mem_gnt[k]    = 1'b1;
                    burst_addr[k] = maddr_v[k];
                    bursts[k]++;
                    beat_cnt[k]   = 0;
                    word[k]       = img_read(maddr_v[k]);
                    phase[k]      = 2;
                end else begin
                    cnt[k]--;
                end
            end else begin
                if ($urandom_range(0, 3) != 0) begin
                    mem_rvalid[k] = 1'b1;
                    mem_rdata[k]  = word[k][16*beat_cnt[k] +: 16];
                    beat_cnt[k]++;
                    if (beat_cnt[k] == 4) begin
                        phase[k]         = 0;
                        last_beat_cyc[k] = cyc;
                    end
                end
            end
        end
    end

    // Reference model: what each responder's cache should hold
    bit          cen[2];
    bit          mvalid[2];
    logic [19:0] mtag[2];
    logic [63:0] mline[2];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_flush(input int k);
        flush[k] = 1'b1;
        @(negedge clk);
        flush[k] = 1'b0;
        @(negedge clk);
        mvalid[k] = 1'b0;
    endtask

    // One complete fetch; optional flush pulse fa negedges after the toggle
    task automatic do_fetch(input int k, input logic [22:0] addr, input int flush_at, input string tag);
        logic [19:0] row;
        logic [26:0] ea;
        logic [63:0] ed;
        bit          exp_hit;
        int          b0, n, fa;
        row     = addr[22:3];
        ea      = BASE + {4'b0000, row, 3'b000};
        exp_hit = cen[k] && mvalid[k] && (mtag[k] == row);
        ed      = exp_hit ? mline[k] : img_read(ea);
        fa      = (exp_hit && flush_at > 0) ? 2 : flush_at;
        b0      = bursts[k];
        rom_address[k] = addr;
        rom_req[k]     = ~rom_req[k];
        n = 0;
        while (ack_v[k] != rom_req[k] && n < 200) begin
            @(negedge clk);
            n++;
            flush[k] = (n == fa);
        end
        flush[k] = 1'b0;
        check({tag, "_ack"}, 64'(ack_v[k]), 64'(rom_req[k]));
        check({tag, "_data"}, data_v[k], ed);
        check({tag, "_bursts"}, 64'(bursts[k] - b0), exp_hit ? 64'd0 : 64'd1);
        if (exp_hit) begin
            check({tag, "_hit_latency"}, 64'(n), 64'd3);
        end else begin
            check({tag, "_mem_addr"}, 64'(burst_addr[k]), 64'(ea));
            check({tag, "_miss_latency"}, 64'(cyc - last_beat_cyc[k]), 64'd2);
        end
        repeat (3) @(negedge clk);
        check({tag, "_ack_once"}, 64'(ack_v[k]), 64'(rom_req[k]));
        check({tag, "_data_stable"}, data_v[k], ed);
        if (fa > 0) mvalid[k] = 1'b0;
        if (!exp_hit) begin
            mvalid[k] = cen[k] && (fa <= 0);
            mtag[k]   = row;
            mline[k]  = ed;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] rows[4];
        logic [22:0] a;
        int          k, b0, n, fa;

        reset_n     = 1'b0;
        rom_req     = '0;
        rom_address = '0;
        flush       = '0;
        junk_en     = 1'b0;
        gnt_delay   = '{-1, -1};
        cen         = '{1'b1, 1'b0};
        mvalid      = '{1'b0, 1'b0};
        repeat (3) @(negedge clk);
        check("reset_ack", 64'(ack_v), 64'd0);
        check("reset_mem_req", 64'(mreq_v), 64'd0);
        check("reset_data_a", data_v[0], 64'd0);
        check("reset_data_b", data_v[1], 64'd0);
        check("reset_mem_addr", 64'(maddr_v[0]), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Directed miss with known beats, then hit on the same row
        img[BASE + 27'h012348] = 64'h4444_3333_2222_1111;
        gnt_delay[0] = 2;
        do_fetch(0, 23'h012348, 0, "miss");
        check("miss_known_word", data_v[0], 64'h4444_3333_2222_1111);
        do_fetch(0, 23'h012348, 0, "hit");

        // Flush while idle, then flush during a burst
        idle_flush(0);
        do_fetch(0, 23'h012348, 0, "flush_refetch");
        do_fetch(0, 23'h0200F0, 4, "flush_in_burst");
        do_fetch(0, 23'h0200F0, 0, "after_burst_flush");

        // Byte offset bits are ignored
        do_fetch(0, 23'h033335, 0, "lowbits_miss");
        check("lowbits_addr_aligned", 64'(burst_addr[0][2:0]), 64'd0);
        do_fetch(0, 23'h033330, 0, "lowbits_hit");

        // Cache disabled: every fetch bursts
        for (int i = 0; i < 3; i++) do_fetch(1, 23'h012348, 0, "nocache");

        // Reset in the middle of a burst
        gnt_delay[0] = 0;
        idle_flush(0);
        b0 = bursts[0];
        rom_address[0] = 23'h0A5550;
        rom_req[0]     = ~rom_req[0];
        n = 0;
        while (!(bursts[0] > b0 && beat_cnt[0] >= 2) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rst_reach_beat2", 64'(n < 200), 64'd1);
        @(negedge clk);
        reset_n = 1'b0;
        rom_req = '0;
        @(negedge clk);
        check("rst_ack", 64'(ack_v), 64'd0);
        check("rst_mem_req", 64'(mreq_v), 64'd0);
        check("rst_data", data_v[0], 64'd0);
        reset_n = 1'b1;
        mvalid  = '{1'b0, 1'b0};
        @(negedge clk);
        do_fetch(0, 23'h0A5550, 0, "post_reset");
        check("post_reset_beats", 64'(beat_cnt[0]), 64'd4);

        // Randomised traffic over a few rows, with flushes and ROM rewrites
        junk_en   = 1'b1;
        gnt_delay = '{-1, -1};
        rows[0] = 20'h02469;
        for (int i = 1; i < 4; i++) rows[i] = 20'($urandom);
        for (int i = 0; i < 60; i++) begin
            k = int'($urandom_range(0, 1));
            a = {rows[$urandom_range(0, 3)], 3'($urandom)};
            if ($urandom_range(0, 7) == 0) idle_flush(k);
            if ($urandom_range(0, 7) == 0) begin
                img[BASE + {4'b0000, rows[$urandom_range(0, 3)], 3'b000}] = {$urandom, $urandom};
                if ($urandom_range(0, 1) == 0) idle_flush(k);
            end
            fa = ($urandom_range(0, 5) == 0) ? int'($urandom_range(2, 4)) : 0;
            do_fetch(k, a, fa, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
